// File: rtl/srng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srng_pkg
// Description : Shared constants and FSM encoding for the SRNG UART streamer.
//               SRNG_STREAM_SYNC_EN adds the SYNC state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package srng_pkg;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_DATA   = 8'h10;
    localparam int         READY       = 0;
    localparam int         ERROR       = 1;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POLL = 3'd1,
        ST_READ = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4
`ifdef SRNG_STREAM_SYNC_EN
        ,
        ST_SYNC = 3'd5
`endif
    } state_t;
endpackage
`default_nettype wire

// File: rtl/srng_uart_streamer_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter; done pulses for one cycle after the
//               stop bit has been held for its full period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam logic [15:0] c_bit_last = 16'(CLKS_PER_BIT - 1);

    logic        r_active;
    logic [15:0] r_cnt;
    logic [3:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_done;

    // r_bit: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= 16'd0;
            r_bit    <= 4'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (start) begin
                    r_active <= 1'b1;
                    r_cnt    <= 16'd0;
                    r_bit    <= 4'd0;
                    r_shift  <= data;
                    r_tx     <= 1'b0;
                end
            end else if (r_cnt == c_bit_last) begin
                r_cnt <= 16'd0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    if (r_bit == 4'd8) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign tx   = r_tx;
    assign done = r_done;
endmodule
`default_nettype wire

// File: rtl/srng_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module      : srng_uart_streamer
// Description : Polls the srng core for ready words and streams each one as
//               four LSB-first UART bytes. Define SRNG_STREAM_SYNC_EN to
//               prefix every word with the 0xA5 sync byte.
// Revision    : 1.0 - initial release
// ============================================================================
module srng_uart_streamer
    import srng_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        core_cs,
    output logic        core_we,
    output logic [7:0]  core_address,
    output logic [31:0] core_write_data,
    input  logic [31:0] core_read_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        error,
    output logic [31:0] words_sent
);
    state_t      r_state;
    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic        r_tx_start;
    logic        r_core_cs;
    logic [7:0]  r_core_address;
    logic        r_busy;
    logic        r_error;
    logic [31:0] r_words_sent;
    logic [7:0]  w_tx_data;
    logic        w_tx_done;

    always_comb begin
        w_tx_data = r_word[{r_byte_idx, 3'b000} +: 8];
`ifdef SRNG_STREAM_SYNC_EN
        if (r_state == ST_SYNC) w_tx_data = SYNC_BYTE;
`endif
    end

    // Outputs are registered: each transition sets what the next state drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_word         <= 32'd0;
            r_byte_idx     <= 2'd0;
            r_tx_start     <= 1'b0;
            r_core_cs      <= 1'b0;
            r_core_address <= 8'h00;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_words_sent   <= 32'd0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_busy <= 1'b1;
`ifdef SRNG_STREAM_SYNC_EN
                        r_state    <= ST_SYNC;
                        r_tx_start <= 1'b1;
`else
                        r_state        <= ST_POLL;
                        r_core_cs      <= 1'b1;
                        r_core_address <= ADDR_STATUS;
`endif
                    end
                end
                ST_POLL: begin
                    if (core_read_data[ERROR]) r_error <= 1'b1;
                    if (core_read_data[READY]) begin
                        r_state        <= ST_READ;
                        r_core_address <= ADDR_DATA;
                    end
                end
                ST_READ: begin
                    r_word     <= core_read_data;
                    r_byte_idx <= 2'd0;
                    r_core_cs  <= 1'b0;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_tx_done) begin
                        if (r_byte_idx == 2'd3) begin
                            r_words_sent <= r_words_sent + 32'd1;
                            if (enable) begin
`ifdef SRNG_STREAM_SYNC_EN
                                r_state    <= ST_SYNC;
                                r_tx_start <= 1'b1;
`else
                                r_state        <= ST_POLL;
                                r_core_cs      <= 1'b1;
                                r_core_address <= ADDR_STATUS;
`endif
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx_start <= 1'b1;
                            r_state    <= ST_SEND;
                        end
                    end
                end
`ifdef SRNG_STREAM_SYNC_EN
                ST_SYNC: begin
                    if (w_tx_done) begin
                        r_state        <= ST_POLL;
                        r_core_cs      <= 1'b1;
                        r_core_address <= ADDR_STATUS;
                    end
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_core_cs <= 1'b0;
                end
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .start (r_tx_start),
        .data  (w_tx_data),
        .tx    (uart_tx),
        .done  (w_tx_done)
    );

    assign core_cs         = r_core_cs;
    assign core_we         = 1'b0;
    assign core_address    = r_core_address;
    assign core_write_data = 32'd0;
    assign busy            = r_busy;
    assign error           = r_error;
    assign words_sent      = r_words_sent;
endmodule
`default_nettype wire

// File: tb/tb_srng_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_srng_uart_streamer
// Description : Self-checking bench: core register model, UART byte decoder
//               and expected-byte scoreboard for srng_uart_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srng_uart_streamer;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        core_cs;
    logic        core_we;
    logic [7:0]  core_address;
    logic [31:0] core_write_data;
    logic [31:0] core_read_data;
    logic        uart_tx;
    logic        busy;
    logic        error;
    logic [31:0] words_sent;

    // core model controls (driven only by the stimulus process)
    logic [31:0] m_data = 32'h0;
    logic        m_err = 1'b0;
    int          words_allowed = 0;

    // observation counters (written only by the negedge/posedge monitors)
    int          cyc = 0;
    int          data_reads = 0;
    int          stall_reads = 0;
    int          cs_cycles = 0;
    int          tx_low = 0;
    int          rx_count = 0;
    int          frame_err = 0;
    logic [7:0]  rx_byte = 8'h0;
    logic        mon_act = 1'b0;
    int          mon_cnt = 0;
    logic [7:0]  mon_sh = 8'h0;

    logic [8:0]  exp_q[$];
    int          rx_seen = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        ready_w;

    srng_uart_streamer #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .core_cs         (core_cs),
        .core_we         (core_we),
        .core_address    (core_address),
        .core_write_data (core_write_data),
        .core_read_data  (core_read_data),
        .uart_tx         (uart_tx),
        .busy            (busy),
        .error           (error),
        .words_sent      (words_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign ready_w = (data_reads < words_allowed);

    always_comb begin
        core_read_data = 32'h0;
        if (core_cs) begin
            if (core_address == 8'h09)      core_read_data = {30'h0, m_err, ready_w};
            else if (core_address == 8'h10) core_read_data = m_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (core_cs) cs_cycles++;
            if (core_cs && core_address == 8'h10) data_reads++;
            if (core_cs && core_address == 8'h09 && !ready_w) stall_reads++;
            if (uart_tx == 1'b0) tx_low++;
        end
    end

    // UART decoder: samples each bit at its centre, aborts on reset
    always @(negedge clk) begin
        if (reset) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (uart_tx == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                if (mon_cnt / CPB == 0) begin
                    if (uart_tx !== 1'b0) begin
                        frame_err++;
                        mon_act = 1'b0;
                    end
                end else if (mon_cnt / CPB <= 8) begin
                    mon_sh[mon_cnt / CPB - 1] = uart_tx;
                end else begin
                    if (uart_tx !== 1'b1) frame_err++;
                    rx_byte = mon_sh;
                    rx_count++;
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [8:0] exp;
        @(posedge clk);
        #1;
        if (rx_count != rx_seen) begin
            rx_seen = rx_count;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h100;
            check_eq("rx_byte", {23'h0, 1'b0, rx_byte}, {23'h0, exp});
        end
    endtask

    task automatic push_word(input logic [31:0] w);
`ifdef SRNG_STREAM_SYNC_EN
        exp_q.push_back(9'h0A5);
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, w[8*i +: 8]});
    endtask

    task automatic grant_word(input logic [31:0] w);
        m_data = w;
        push_word(w);
        words_allowed = data_reads + 1;
    endtask

    task automatic wait_words(input logic [31:0] target, input string tag);
        int n = 0;
        while (words_sent != target && n < 1000) begin
            tick();
            n++;
        end
        check_eq(tag, words_sent, target);
    endtask

    task automatic wait_tx_low();
        int n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int en_cyc;
        int s_stall;
        int s_tx;
        int s_data;
        int s_cs;
        int s_rx;
        int n;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_error", {31'h0, error}, 32'h0);
        check_eq("rst_words_sent", words_sent, 32'h0);
        check_eq("rst_core_cs", {31'h0, core_cs}, 32'h0);
        check_eq("rst_core_address", {24'h0, core_address}, 32'h0);

        // single word, ready immediately
        grant_word(32'h12345678);
        enable = 1'b1;
        en_cyc = cyc;
        wait_tx_low();
`ifdef SRNG_STREAM_SYNC_EN
        check_eq("start_latency", cyc - en_cyc, 32'd2);
`else
        check_eq("start_latency", cyc - en_cyc, 32'd4);
`endif
        check_eq("core_we", {31'h0, core_we}, 32'h0);
        check_eq("core_write_data", core_write_data, 32'h0);
        wait_words(32'd1, "single_words_sent");
        enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_eq("reset_clears_words", words_sent, 32'h0);

        // ready stall: 20 STATUS reads return not-ready
        s_tx = tx_low;
        s_data = data_reads;
        enable = 1'b1;
        n = 0;
        while (core_cs !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        s_stall = stall_reads;
        s_tx = tx_low;
        repeat (20) tick();
        check_eq("stall_status_reads", stall_reads - s_stall, 32'd20);
        check_eq("stall_tx_activity", tx_low - s_tx, 32'd0);
        check_eq("stall_data_reads", data_reads - s_data, 32'd0);
        grant_word(32'h89ABCDEF);
        wait_words(32'd1, "stall_words_sent");
        check_eq("stall_one_data_read", data_reads - s_data, 32'd1);

        // error flag: one STATUS read returns 0x3
        grant_word(32'hCAFEF00D);
        m_err = 1'b1;
        tick();
        m_err = 1'b0;
        check_eq("error_set", {31'h0, error}, 32'h1);
        wait_words(32'd2, "error_words_sent");
        grant_word(32'h0F1E2D3C);
        wait_words(32'd3, "clean_words_sent");
        check_eq("error_sticky", {31'h0, error}, 32'h1);

        // enable drops during byte 1: word completes, then IDLE
        grant_word(32'hA1B2C3D4);
        s_rx = rx_count;
        n = 0;
`ifdef SRNG_STREAM_SYNC_EN
        while (rx_count < s_rx + 2 && n < 1000) begin
`else
        while (rx_count < s_rx + 1 && n < 1000) begin
`endif
            tick();
            n++;
        end
        repeat (8) tick();
        enable = 1'b0;
        wait_words(32'd4, "drop_words_sent");
        s_cs = cs_cycles;
        words_allowed = data_reads + 1;
        repeat (30) tick();
        check_eq("drop_busy", {31'h0, busy}, 32'h0);
        check_eq("drop_no_core_cs", cs_cycles - s_cs, 32'd0);
        check_eq("drop_words_hold", words_sent, 32'd4);

        // reset during a data bit
        enable = 1'b1;
        wait_tx_low();
        repeat (6) tick();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        check_eq("midrst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check_eq("midrst_words_sent", words_sent, 32'h0);
        check_eq("midrst_busy", {31'h0, busy}, 32'h0);
        check_eq("midrst_core_cs", {31'h0, core_cs}, 32'h0);
        check_eq("midrst_error", {31'h0, error}, 32'h0);
        reset = 1'b0;
        tick();
        grant_word(32'h5A0FF0C3);
        enable = 1'b1;
        wait_words(32'd1, "restart_words_sent");
        enable = 1'b0;
        repeat (60) tick();

        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        check_eq("frame_errors", frame_err, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
